// File: rtl/sha256_msg_schedule_pkg.sv
// Shared definitions for the SHA-256 message schedule: FSM encoding, block
// sizes, sigma rotation amounts and a word rotate helper.
package sha256_msg_schedule_pkg;

  localparam int WORD_W   = 32;
  localparam int N_LOAD   = 16;
  localparam int N_ROUNDS = 64;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Small sigma (schedule) rotation/shift amounts
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Big sigma, shared with the compression core (sel=0: Sigma0, sel=1: Sigma1)
  function automatic logic [WORD_W-1:0] sigma_big(input logic [WORD_W-1:0] x, input logic sel);
    if (sel) return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    else     return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Load/stream bus between input memory, the schedule block and the
// compression datapath.
interface sha256_msg_schedule_if;
  import sha256_msg_schedule_pkg::*;

  logic                 start;
  logic [WORD_W-1:0]    word_in;
  logic                 word_valid;
  logic                 word_ready;
  logic [WORD_W-1:0]    w_out;
  logic [CNT_W-1:0]     w_idx;
  logic                 w_valid;
  logic                 w_ready;
  logic                 busy;
  logic                 done;

  modport master (
    output start, word_in, word_valid, w_ready,
    input  word_ready, w_out, w_idx, w_valid, busy, done
  );

  modport slave (
    input  start, word_in, word_valid, w_ready,
    output word_ready, w_out, w_idx, w_valid, busy, done
  );
endinterface

// File: rtl/sha256_sigma_small.sv
// SHA-256 small sigma: sel=0 gives s0, sel=1 gives s1.
module sha256_sigma_small
  import sha256_msg_schedule_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic              sel,
  output logic [WORD_W-1:0] s
);

  always_comb begin
    if (sel) s = rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    else     s = rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads W0..W15 into a 16-word sliding window and
// streams W0..W63, appending one expanded word per accepted output.
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  sha256_msg_schedule_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  win_q [N_LOAD];
  logic [WORD_W-1:0]  win_d [N_LOAD];
  logic [WORD_W-1:0]  s0_w, s1_w, w_new;

  sha256_sigma_small u_s0 (.x(win_q[1]),  .sel(1'b0), .s(s0_w));
  sha256_sigma_small u_s1 (.x(win_q[14]), .sel(1'b1), .s(s1_w));

  // W[t+16] from the current window; wraps modulo 2^32
  assign w_new = s1_w + win_q[9] + s0_w + win_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int j = 0; j < N_LOAD; j++) win_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.word_valid) begin
          win_d[cnt_q[3:0]] = bus.word_in;
          if (cnt_q == CNT_W'(N_LOAD - 1)) begin
            cnt_d   = '0;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (bus.w_ready) begin
          for (int j = 0; j < N_LOAD - 1; j++) win_d[j] = win_q[j+1];
          win_d[N_LOAD-1] = w_new;
          if (cnt_q == CNT_W'(N_ROUNDS - 1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only, so they are glitch-free and zero in reset
  always_comb begin
    bus.word_ready = (state_q == ST_LOAD);
    bus.w_valid    = (state_q == ST_EMIT);
    bus.w_out      = (state_q == ST_EMIT) ? win_q[0] : '0;
    bus.w_idx      = (state_q == ST_EMIT) ? cnt_q    : '0;
    bus.busy       = (state_q == ST_LOAD) || (state_q == ST_EMIT);
    bus.done       = (state_q == ST_DONE);
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule stage.
- Loads the 16 input words W0..W15 of one 512-bit block from input memory.
- Expands them to W0..W63 and streams one word per accepted handshake to the round/compression datapath, in step with the round counter (k_num).
- Sits between the input-memory read port and the compression core.

Parameters:
- WORD_W, 32, data word width; only 32 is supported.
- N_LOAD, 16, words loaded per block.
- N_ROUNDS, 64, words emitted per block.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; module is in reset while low
- start  input  1  single-cycle pulse that begins a block; honoured only in IDLE
- word_in  input  32  message word from input memory
- word_valid  input  1  word_in is valid
- word_ready  output  1  block accepts word_in this cycle (high only in LOAD)
- w_out  output  32  schedule word W[t]
- w_idx  output  6  index t of w_out
- w_valid  output  1  w_out/w_idx valid (high only in EMIT)
- w_ready  input  1  consumer takes w_out this cycle
- busy  output  1  high in LOAD and EMIT
- done  output  1  one-cycle pulse after W63 is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low.
- Reset values: state=IDLE, all window regs=0, counter=0, word_ready=0, w_valid=0, w_idx=0, w_out=0, busy=0, done=0.
- Window: 16x32 register file win[0..15]. In EMIT, win[j] holds W[t+j].
- Counter cnt (6 bits) tracks words loaded or emitted.

State machine (IDLE, LOAD, EMIT, DONE):
- IDLE:
  - start=1 -> LOAD, cnt=0.
  - word_valid is ignored.
- LOAD:
  - word_ready=1 (registered, asserted from the first LOAD cycle).
  - On word_valid&word_ready: win[cnt]<=word_in; cnt<=cnt+1.
  - On the 16th accept (cnt==15): cnt<=0 -> EMIT.
  - Gaps in word_valid stall with no loss of data.
- EMIT:
  - w_valid=1, w_out=win[0], w_idx=cnt.
  - On w_ready: shift win[j]<=win[j+1] for j=0..14; win[15]<=W_new; cnt<=cnt+1.
  - w_ready=0 holds all outputs and state stable.
  - On the accept with cnt==63 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in DONE.

Arithmetic:
- W_new = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32; carries are discarded.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- W_new is computed combinationally from the window; there is no extra pipeline stage.

Latency:
- First word_ready: cycle after start.
- W0 valid: cycle after the 16th load accept.
- With w_ready held at 1, one word per cycle: 64 cycles for W0..W63, then done.
- Appended words for t>=48 are computed but never emitted; this is harmless.

Boundary conditions:
- start outside IDLE: ignored, no restart.
- start and word_valid in the same IDLE cycle: word ignored (word_ready still 0).
- Reset asserted mid-LOAD or mid-EMIT: immediate return to reset values; the partial block is discarded.
- cnt never wraps in-state: the terminal counts 15 (LOAD) and 63 (EMIT) force transitions.
- w_idx is exactly cnt; w_idx of 63 is followed by done.

Decomposition:
- Shared include sha256_defs.vh holds:
  - State encodings (IDLE=2'd0, LOAD=2'd1, EMIT=2'd2, DONE=2'd3).
  - N_LOAD, N_ROUNDS.
  - Rotation amounts for s0/s1 (and Σ0/Σ1, reused by the compression core).
- One combinational sub-module, sha256_sigma_small (inputs x, sel; output s0 or s1), instantiated twice.

Test Plan:
- Load "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> 64 words emitted back-to-back:
  - W0..W15 match the inputs; W16=0x61626380; W17=0x000F0000.
  - All 64 words match the golden C model; done pulses the cycle after w_idx=63.
- Same block with word_valid toggling 1/0 and w_ready random 50% -> identical W sequence; outputs stable while w_ready=0.
- start pulsed during LOAD (after 5 words) and during EMIT (t=30) -> ignored; sequence and done timing unchanged.
- reset driven low at EMIT t=20 -> all outputs 0 in the same cycle. A fresh start then loads the all-0xFFFFFFFF block -> output matches the golden model.
- Two back-to-back blocks, with start issued the cycle after done -> second block's W0 is emitted correctly with no carry-over from the first window.
- word_valid=1 in IDLE with word_in=0xDEADBEEF, no start -> word_ready=0, busy=0, no state change.
